// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad switch model: plays a key press (bounce-in, hold, bounce-out, gap) onto col.
// Define KEYPAD_BOUNCE_EN to include the bounce phases; otherwise a press is a clean hold then gap.
module keypad_emulator #(
  parameter logic [31:0] HOLD_CYCLES    = 32'd2_000_000,
  parameter logic [31:0] GAP_CYCLES     = 32'd1_000_000,
  parameter logic [31:0] BOUNCE_PERIOD  = 32'd20_000,
  parameter logic [7:0]  BOUNCE_TOGGLES = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } state_t;

  // Returns {row, col} position of a hex key on the keypad face.
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    case (key)
      4'h1:    key_pos = {2'd0, 2'd0};
      4'h2:    key_pos = {2'd0, 2'd1};
      4'h3:    key_pos = {2'd0, 2'd2};
      4'hA:    key_pos = {2'd0, 2'd3};
      4'h4:    key_pos = {2'd1, 2'd0};
      4'h5:    key_pos = {2'd1, 2'd1};
      4'h6:    key_pos = {2'd1, 2'd2};
      4'hB:    key_pos = {2'd1, 2'd3};
      4'h7:    key_pos = {2'd2, 2'd0};
      4'h8:    key_pos = {2'd2, 2'd1};
      4'h9:    key_pos = {2'd2, 2'd2};
      4'hC:    key_pos = {2'd2, 2'd3};
      4'hE:    key_pos = {2'd3, 2'd0};
      4'h0:    key_pos = {2'd3, 2'd1};
      4'hF:    key_pos = {2'd3, 2'd2};
      4'hD:    key_pos = {2'd3, 2'd3};
      default: key_pos = {2'd0, 2'd0};
    endcase
  endfunction

  state_t      state_r;
  logic [31:0] cnt_r;
  logic [1:0]  kr_r;
  logic [1:0]  kc_r;
  logic        contact_r;
  logic        ready_r;
  logic        busy_r;
  logic        done_r;

`ifdef KEYPAD_BOUNCE_EN
  logic [7:0]  phase_r;
`else
  logic        unused_cfg_s;
  assign unused_cfg_s = ^{BOUNCE_PERIOD, BOUNCE_TOGGLES};
`endif

  // Press-sequence FSM with its cycle/phase counters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 32'd0;
      kr_r      <= 2'd0;
      kc_r      <= 2'd0;
      contact_r <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
      phase_r   <= 8'd0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid && ready_r) begin
            {kr_r, kc_r} <= key_pos(cmd_key);
            cnt_r        <= 32'd0;
            contact_r    <= 1'b1;
            ready_r      <= 1'b0;
            busy_r       <= 1'b1;
`ifdef KEYPAD_BOUNCE_EN
            phase_r      <= 8'd0;
            state_r      <= BOUNCE_IN;
`else
            state_r      <= HOLD;
`endif
          end
        end
`ifdef KEYPAD_BOUNCE_EN
        BOUNCE_IN: begin
          if (cnt_r == BOUNCE_PERIOD - 32'd1) begin
            cnt_r <= 32'd0;
            if (phase_r == BOUNCE_TOGGLES - 8'd1) begin
              phase_r   <= 8'd0;
              contact_r <= 1'b1;
              state_r   <= HOLD;
            end else begin
              // next phase k+1 is closed when (k+1) is even, i.e. when k is odd
              phase_r   <= phase_r + 8'd1;
              contact_r <= phase_r[0];
            end
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
`endif
        HOLD: begin
          if (cnt_r == HOLD_CYCLES - 32'd1) begin
            cnt_r     <= 32'd0;
            contact_r <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
            phase_r   <= 8'd0;
            state_r   <= BOUNCE_OUT;
`else
            state_r   <= GAP;
`endif
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
`ifdef KEYPAD_BOUNCE_EN
        BOUNCE_OUT: begin
          if (cnt_r == BOUNCE_PERIOD - 32'd1) begin
            cnt_r <= 32'd0;
            if (phase_r == BOUNCE_TOGGLES - 8'd1) begin
              phase_r   <= 8'd0;
              contact_r <= 1'b0;
              state_r   <= GAP;
            end else begin
              phase_r   <= phase_r + 8'd1;
              contact_r <= ~phase_r[0];
            end
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
`endif
        GAP: begin
          if (cnt_r == GAP_CYCLES - 32'd1) begin
            cnt_r     <= 32'd0;
            contact_r <= 1'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= IDLE;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        default: begin
          cnt_r     <= 32'd0;
          contact_r <= 1'b0;
          ready_r   <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Switch path: the closed key connects its row line straight through to its column line.
  always_comb begin
    if (contact_r && row[kr_r]) begin
      col = 4'b0001 << kc_r;
    end else begin
      col = 4'b0000;
    end
  end

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: directed scenarios plus random traffic against a contact-timeline model.
module tb_keypad_emulator;

  localparam logic [31:0] HOLD = 32'd20;
  localparam logic [31:0] GAPC = 32'd10;
  localparam logic [31:0] BP   = 32'd3;
  localparam logic [7:0]  BT   = 8'd4;
`ifdef KEYPAD_BOUNCE_EN
  localparam bit BOUNCE_ON = 1'b1;
`else
  localparam bit BOUNCE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_key = 4'h0;
  logic [3:0] row = 4'b0000;
  logic       cmd_ready;
  logic [3:0] col;
  logic       busy;
  logic       done;

  keypad_emulator #(
    .HOLD_CYCLES   (HOLD),
    .GAP_CYCLES    (GAPC),
    .BOUNCE_PERIOD (BP),
    .BOUNCE_TOGGLES(BT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_key  (cmd_key),
    .row      (row),
    .col      (col),
    .busy     (busy),
    .done     (done)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press is a precomputed list of per-cycle contact values.
  bit [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_pos  = 0;
  int m_r    = 0;
  int m_c    = 0;
  bit m_seq[$];

  task automatic build_seq();
    m_seq.delete();
    if (BOUNCE_ON) begin
      for (int k = 0; k < int'(BT); k++)
        for (int j = 0; j < int'(BP); j++) m_seq.push_back(k % 2 == 0);
    end
    for (int j = 0; j < int'(HOLD); j++) m_seq.push_back(1'b1);
    if (BOUNCE_ON) begin
      for (int k = 0; k < int'(BT); k++)
        for (int j = 0; j < int'(BP); j++) m_seq.push_back(k % 2 == 1);
    end
    for (int j = 0; j < int'(GAPC); j++) m_seq.push_back(1'b0);
  endtask

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (cmd_valid) begin
        for (int i = 0; i < 16; i++)
          if (layout[i] == cmd_key) begin
            m_r = i / 4;
            m_c = i % 4;
          end
        build_seq();
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end else begin
      m_pos++;
      m_done = 1'b0;
      if (m_pos >= m_seq.size()) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    logic       e_contact;
    logic       e_busy;
    logic [3:0] e_col;
    @(negedge clk);
    e_busy    = m_busy && !reset;
    e_contact = e_busy ? m_seq[m_pos] : 1'b0;
    e_col     = (e_contact && row[m_r]) ? (4'b0001 << m_c) : 4'b0000;
    chk4("col", col, e_col);
    chk1("busy", busy, e_busy);
    chk1("cmd_ready", cmd_ready, !e_busy);
    chk1("done", done, m_done && !reset);
  end

  task automatic press(input logic [3:0] k);
    cmd_key   = k;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cur = 1;
  endtask

  task automatic at(input int k);
    repeat (k - cur) @(posedge clk);
    cur = k;
    @(negedge clk);
  endtask

  task automatic lit(input int k, input string name, input logic [3:0] e_col);
    at(k);
    chk4(name, col, e_col);
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk1("done_seen", seen, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int hits;
    @(negedge clk);
    chk4("reset_col", col, 4'b0000);
    chk1("reset_ready", cmd_ready, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    row = 4'b0010;
    @(posedge clk);
    #1;

    // Key 5 with row 1 held: pinned literal timeline.
    press(4'h5);
    if (BOUNCE_ON) begin
      lit(1,  "t1_c1",  4'b0010);
      lit(3,  "t1_c3",  4'b0010);
      lit(4,  "t1_c4",  4'b0000);
      lit(6,  "t1_c6",  4'b0000);
      lit(7,  "t1_c7",  4'b0010);
      lit(10, "t1_c10", 4'b0000);
      lit(13, "t1_c13", 4'b0010);
      lit(32, "t1_c32", 4'b0010);
      lit(33, "t1_c33", 4'b0000);
      lit(36, "t1_c36", 4'b0010);
      lit(39, "t1_c39", 4'b0000);
      lit(44, "t1_c44", 4'b0010);
      lit(45, "t1_c45", 4'b0000);
      lit(54, "t1_c54", 4'b0000);
      chk1("t1_busy54", busy, 1'b1);
      chk1("t1_done54", done, 1'b0);
      at(55);
      chk1("t1_done55", done, 1'b1);
      chk1("t1_ready55", cmd_ready, 1'b1);
    end else begin
      lit(1,  "t1_c1",  4'b0010);
      lit(20, "t1_c20", 4'b0010);
      lit(21, "t1_c21", 4'b0000);
      lit(30, "t1_c30", 4'b0000);
      chk1("t1_busy30", busy, 1'b1);
      chk1("t1_done30", done, 1'b0);
      at(31);
      chk1("t1_done31", done, 1'b1);
      chk1("t1_ready31", cmd_ready, 1'b1);
    end

    // Key D with a rotating row drive: column 3 only when row 3 is driven.
    @(posedge clk);
    #1 row = 4'b0001;
    press(4'hD);
    hits = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      row = 4'b0001 << (i % 4);
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (col != 4'b0000) begin
          chk4("sweep_row", row, 4'b1000);
          hits++;
        end
        @(posedge clk);
        #1;
      end
    end
    chk1("sweep_done", seen, 1'b1);
    chk1("sweep_hits", hits > 0, 1'b1);

    // Key E with row 2 driven: never any column, done still pulses.
    @(posedge clk);
    #1 row = 4'b0100;
    press(4'hE);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      chk4("mismatch_col", col, 4'b0000);
      if (done) seen = 1'b1;
    end
    chk1("mismatch_done", seen, 1'b1);

    // Key 3 offered mid-press of key 7 is ignored, then taken in the done cycle.
    @(posedge clk);
    #1 row = 4'b0101;
    press(4'h7);
    at(15);
    chk4("b2b_key7_col", col, 4'b0001);
    cmd_key   = 4'h3;
    cmd_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk1("b2b_done", seen, 1'b1);
    chk1("b2b_ready", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk4("b2b_first_col", col, 4'b0100);
    chk1("b2b_busy", busy, 1'b1);
    cmd_valid = 1'b0;
    wait_done(200);

    // Reset in the middle of HOLD.
    @(posedge clk);
    #1 row = 4'b0010;
    press(4'h5);
    at(15);
    chk4("pre_reset_col", col, 4'b0010);
    #1 reset = 1'b1;
    #1 chk4("reset_mid_col", col, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("post_reset_ready", cmd_ready, 1'b1);
    chk1("post_reset_busy", busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk1("post_reset_no_done", seen, 1'b0);

    // Random traffic: mostly one-hot rows, sporadic commands and resets.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 7) row = 4'b0001 << $urandom_range(0, 3);
      else row = 4'($urandom_range(0, 15));
      cmd_valid = ($urandom_range(0, 9) == 0);
      cmd_key   = 4'($urandom_range(0, 15));
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
      @(posedge clk);
      #1;
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
